// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control unit for the cs147sec05 data path: FETCH/DECODE/EXE/MEM/WB.
// Define PROC_ILLEGAL_TRAP_EN to trap unknown instructions into a sticky HALT.
module proc_ctrl_fsm (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INSTRUCTION,
  input  logic        ZERO,
  output logic [31:0] CTRL,
  output logic        READ,
  output logic        WRITE,
  output logic        ILLEGAL
);

  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_MUL = 5'd3;
  localparam logic [4:0] ALU_SHR = 5'd4;
  localparam logic [4:0] ALU_SHL = 5'd5;
  localparam logic [4:0] ALU_AND = 5'd6;
  localparam logic [4:0] ALU_OR  = 5'd7;
  localparam logic [4:0] ALU_NOR = 5'd8;
  localparam logic [4:0] ALU_SLT = 5'd9;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXE, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    K_NOP, K_R, K_I, K_LW, K_SW, K_LUI, K_BEQ,
    K_BNE, K_JR, K_J, K_JAL, K_PUSH, K_POP
  } kind_e;

  state_e      state_q, state_d;
  logic        run_q, run_d;
  logic [31:0] ir_q, ir_d;
  logic        zero_q, zero_d;

  kind_e       kind;
  logic [4:0]  alu;
  logic [3:0]  op2;
  logic        op1_sp;
  logic [31:0] exe_w;
  logic [31:0] ctrl;
  logic        taken;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      ir_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      ir_q    <= ir_d;
      zero_q  <= zero_d;
    end
  end

  // run_q holds the unit idle for the first edge after reset release
  always_comb begin
    state_d = state_q;
    run_d   = 1'b1;
    ir_d    = ir_q;
    zero_d  = zero_q;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          state_d = S_DECODE;
          ir_d    = INSTRUCTION;
        end
        S_DECODE: begin
`ifdef PROC_ILLEGAL_TRAP_EN
          state_d = (kind == K_NOP) ? S_HALT : S_EXE;
`else
          state_d = S_EXE;
`endif
        end
        S_EXE: begin
          state_d = S_MEM;
          zero_d  = ZERO;
        end
        S_MEM:   state_d = S_WB;
        S_WB:    state_d = S_FETCH;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // op2 maps onto CTRL[20:17] = {sel_4, sel_3, sel_2, sel_1}
  always_comb begin
    kind   = K_NOP;
    alu    = '0;
    op2    = '0;
    op1_sp = 1'b0;
    case (ir_q[31:26])
      6'h00: begin
        case (ir_q[5:0])
          6'h20: begin kind = K_R; alu = ALU_ADD; op2 = 4'b1000; end
          6'h22: begin kind = K_R; alu = ALU_SUB; op2 = 4'b1000; end
          6'h2c: begin kind = K_R; alu = ALU_MUL; op2 = 4'b1000; end
          6'h24: begin kind = K_R; alu = ALU_AND; op2 = 4'b1000; end
          6'h25: begin kind = K_R; alu = ALU_OR;  op2 = 4'b1000; end
          6'h27: begin kind = K_R; alu = ALU_NOR; op2 = 4'b1000; end
          6'h2a: begin kind = K_R; alu = ALU_SLT; op2 = 4'b1000; end
          6'h01: begin kind = K_R; alu = ALU_SHL; op2 = 4'b0101; end
          6'h02: begin kind = K_R; alu = ALU_SHR; op2 = 4'b0101; end
          6'h08: kind = K_JR;
          default: kind = K_NOP;
        endcase
      end
      6'h02: kind = K_J;
      6'h03: kind = K_JAL;
      6'h04: begin kind = K_BEQ; alu = ALU_SUB; op2 = 4'b1000; end
      6'h05: begin kind = K_BNE; alu = ALU_SUB; op2 = 4'b1000; end
      6'h08: begin kind = K_I; alu = ALU_ADD; op2 = 4'b0010; end
      6'h0a: begin kind = K_I; alu = ALU_SLT; op2 = 4'b0010; end
      6'h0c: begin kind = K_I; alu = ALU_AND; end
      6'h0d: begin kind = K_I; alu = ALU_OR;  end
      6'h0f: kind = K_LUI;
      6'h1b: begin
        kind = K_PUSH; alu = ALU_SUB; op2 = 4'b0100; op1_sp = 1'b1;
      end
      6'h1c: begin
        kind = K_POP; alu = ALU_ADD; op2 = 4'b0100; op1_sp = 1'b1;
      end
      6'h1d: begin kind = K_I;  alu = ALU_MUL; op2 = 4'b0010; end
      6'h23: begin kind = K_LW; alu = ALU_ADD; op2 = 4'b0010; end
      6'h2b: begin kind = K_SW; alu = ALU_ADD; op2 = 4'b0010; end
      default: kind = K_NOP;
    endcase
  end

  always_comb begin
    exe_w        = '0;
    exe_w[25:21] = alu;
    exe_w[20:17] = op2;
    exe_w[16]    = op1_sp;
    exe_w[7:6]   = 2'b11;
    if (kind == K_NOP) exe_w = '0;
  end

  assign taken = (kind == K_BEQ &&  zero_q) ||
                 (kind == K_BNE && !zero_q);

  always_comb begin
    ctrl = '0;
    if (run_q) begin
      case (state_q)
        S_FETCH:  ctrl = 32'hC000_0010;
        S_DECODE: ctrl = 32'h0000_00C0;
        S_EXE:    ctrl = exe_w;
        S_MEM: begin
          ctrl = exe_w;
          case (kind)
            K_LW: ctrl[4] = 1'b1;
            K_SW: ctrl[5] = 1'b1;
            K_PUSH: begin
              ctrl[5]  = 1'b1;
              ctrl[26] = 1'b1;
              ctrl[29] = 1'b1;
              ctrl[6]  = 1'b0;
            end
            K_POP: begin
              ctrl[4]  = 1'b1;
              ctrl[26] = 1'b1;
            end
            default: ;
          endcase
        end
        S_WB: begin
          ctrl      = exe_w;
          ctrl[0]   = 1'b1;
          ctrl[3:1] = 3'b101;
          if (taken) ctrl[3:1] = 3'b110;
          case (kind)
            K_R: ctrl[14:8] = 7'b1001001;
            K_I: ctrl[14:8] = 7'b1001011;
            K_LW: ctrl[14:8] = 7'b1011011;
            K_LUI: ctrl[14:8] = 7'b1101011;
            K_JR: ctrl[3:1] = 3'b100;
            K_J: ctrl[3:1] = 3'b000;
            K_JAL: begin
              ctrl[3:1]  = 3'b000;
              ctrl[14:8] = 7'b0000101;
            end
            K_PUSH: ctrl[15] = 1'b1;
            K_POP: begin
              ctrl[15]   = 1'b1;
              ctrl[14:8] = 7'b1010001;
            end
            default: ;
          endcase
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign CTRL  = ctrl;
  assign READ  = ctrl[4];
  assign WRITE = ctrl[5];
`ifdef PROC_ILLEGAL_TRAP_EN
  assign ILLEGAL = run_q && (state_q == S_HALT);
`else
  assign ILLEGAL = 1'b0;
`endif

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Vector table + scoreboard bench for proc_ctrl_fsm.
// Covers reset, every instruction class, branches, stack ops and mid-run reset.
module tb_proc_ctrl_fsm;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] INSTRUCTION;
  logic        ZERO;
  logic [31:0] CTRL;
  logic        READ;
  logic        WRITE;
  logic        ILLEGAL;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic        z;
    logic [31:0] e2;
    logic [31:0] e3;
    logic [31:0] e4;
  } vec_t;

  vec_t        tv[$];
  logic [31:0] sb[$];

  proc_ctrl_fsm dut (
    .CLK(CLK),
    .RST(RST),
    .INSTRUCTION(INSTRUCTION),
    .ZERO(ZERO),
    .CTRL(CTRL),
    .READ(READ),
    .WRITE(WRITE),
    .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add_v(input logic [31:0] instr, input logic z,
                       input logic [31:0] e2, e3, e4);
    vec_t v;
    v = '{instr, z, e2, e3, e4};
    tv.push_back(v);
  endtask

  task automatic check_out(input string tag, input logic ill);
    logic [31:0] e;
    if (sb.size() == 0) begin
      chk({tag, " sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, " ctrl"}, CTRL, e);
      chk({tag, " read"}, {31'd0, READ}, {31'd0, e[4]});
      chk({tag, " write"}, {31'd0, WRITE}, {31'd0, e[5]});
      chk({tag, " illegal"}, {31'd0, ILLEGAL}, {31'd0, ill});
    end
  endtask

  // Instruction bus carries junk outside FETCH, ZERO is inverted outside EXE
  task automatic one_cycle(input logic [31:0] instr, input logic z,
                           input int s, input logic [31:0] e,
                           input string tag);
    INSTRUCTION = (s == 0) ? instr : 32'hFFFF_FFFF;
    ZERO        = (s == 2) ? z : ~z;
    sb.push_back(e);
    @(negedge CLK);
    check_out($sformatf("%s s%0d", tag, s), 1'b0);
    @(posedge CLK);
    #1;
  endtask

  task automatic run_instr(input logic [31:0] instr, input logic z,
                           input logic [31:0] e2, e3, e4,
                           input string tag);
    logic [31:0] e [5];
    e = '{32'hC000_0010, 32'h0000_00C0, e2, e3, e4};
    for (int s = 0; s < 5; s++) one_cycle(instr, z, s, e[s], tag);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("rst ctrl", CTRL, 32'h0);
      chk("rst read", {31'd0, READ}, 32'd0);
      chk("rst illegal", {31'd0, ILLEGAL}, 32'd0);
    end
    RST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0;
    INSTRUCTION = '0;
    ZERO = 1'b0;

    add_v(32'h0022_1820, 1'b0, 32'h0030_00C0, 32'h0030_00C0, 32'h0030_49CB);
    add_v(32'h0022_1822, 1'b0, 32'h0050_00C0, 32'h0050_00C0, 32'h0050_49CB);
    add_v(32'h0022_182A, 1'b0, 32'h0130_00C0, 32'h0130_00C0, 32'h0130_49CB);
    add_v(32'h0002_1041, 1'b0, 32'h00AA_00C0, 32'h00AA_00C0, 32'h00AA_49CB);
    add_v(32'h1022_0003, 1'b1, 32'h0050_00C0, 32'h0050_00C0, 32'h0050_00CD);
    add_v(32'h1022_0003, 1'b0, 32'h0050_00C0, 32'h0050_00C0, 32'h0050_00CB);
    add_v(32'h1422_0003, 1'b0, 32'h0050_00C0, 32'h0050_00C0, 32'h0050_00CD);
    add_v(32'h1422_0003, 1'b1, 32'h0050_00C0, 32'h0050_00C0, 32'h0050_00CB);
    add_v(32'h8C23_0004, 1'b0, 32'h0024_00C0, 32'h0024_00D0, 32'h0024_5BCB);
    add_v(32'hAC23_0004, 1'b0, 32'h0024_00C0, 32'h0024_00E0, 32'h0024_00CB);
    add_v(32'h2023_0005, 1'b0, 32'h0024_00C0, 32'h0024_00C0, 32'h0024_4BCB);
    add_v(32'h3023_000F, 1'b0, 32'h00C0_00C0, 32'h00C0_00C0, 32'h00C0_4BCB);
    add_v(32'h3C01_0012, 1'b0, 32'h0000_00C0, 32'h0000_00C0, 32'h0000_6BCB);
    add_v(32'h03E0_0008, 1'b0, 32'h0000_00C0, 32'h0000_00C0, 32'h0000_00C9);
    add_v(32'h0800_0010, 1'b0, 32'h0000_00C0, 32'h0000_00C0, 32'h0000_00C1);
    add_v(32'h0C00_0010, 1'b0, 32'h0000_00C0, 32'h0000_00C0, 32'h0000_05C1);
    add_v(32'h6C00_0000, 1'b0, 32'h0049_00C0, 32'h2449_00A0, 32'h0049_80CB);
    add_v(32'h7000_0000, 1'b0, 32'h0029_00C0, 32'h0429_00D0, 32'h0029_D1CB);
`ifndef PROC_ILLEGAL_TRAP_EN
    add_v(32'hFC00_0000, 1'b0, 32'h0, 32'h0, 32'h0000_000B);
    add_v(32'h0000_003F, 1'b0, 32'h0, 32'h0, 32'h0000_000B);
`endif

    do_reset();

    foreach (tv[i])
      run_instr(tv[i].instr, tv[i].z, tv[i].e2, tv[i].e3, tv[i].e4,
                $sformatf("vec%0d", i));

    // Reset dropped during EXE of add: no WB, restart at FETCH
    one_cycle(32'h0022_1820, 1'b0, 0, 32'hC000_0010, "mrst");
    one_cycle(32'h0022_1820, 1'b0, 1, 32'h0000_00C0, "mrst");
    chk("mrst exe", CTRL, 32'h0030_00C0);
    RST = 1'b0;
    #1;
    chk("mrst async ctrl", CTRL, 32'h0);
    chk("mrst async read", {31'd0, READ}, 32'd0);
    repeat (3) begin
      @(negedge CLK);
      chk("mrst hold ctrl", CTRL, 32'h0);
    end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    run_instr(32'h0022_1820, 1'b0, 32'h0030_00C0, 32'h0030_00C0,
              32'h0030_49CB, "after_rst");

`ifdef PROC_ILLEGAL_TRAP_EN
    one_cycle(32'hFC00_0000, 1'b0, 0, 32'hC000_0010, "ill");
    one_cycle(32'hFC00_0000, 1'b0, 1, 32'h0000_00C0, "ill");
    for (int k = 0; k < 20; k++) begin
      INSTRUCTION = 32'h0022_1820;
      @(negedge CLK);
      chk($sformatf("halt%0d ctrl", k), CTRL, 32'h0);
      chk($sformatf("halt%0d illegal", k), {31'd0, ILLEGAL}, 32'd1);
      chk($sformatf("halt%0d rw", k), {30'd0, READ, WRITE}, 32'd0);
      @(posedge CLK);
      #1;
    end
    do_reset();
    run_instr(32'h0022_1820, 1'b0, 32'h0030_00C0, 32'h0030_00C0,
              32'h0030_49CB, "post_halt");
`endif

    chk("sb drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_ctrl_fsm.md
Name: proc_ctrl_fsm

Overview:
- Multi-cycle control unit for the 32-bit cs147sec05 processor.
- Sits directly upstream of the data path: drives its 32-bit CTRL word and the memory READ/WRITE strobes.
- Consumes the data path's INSTRUCTION and ZERO outputs.
- Sequences every instruction through five states: FETCH, DECODE, EXE, MEM, WB.

Parameters:
- ALU_ADD, 5'd1, ALU add code
- ALU_SUB, 5'd2, ALU subtract code
- ALU_MUL, 5'd3, ALU multiply code
- ALU_SHR, 5'd4, ALU shift-right code
- ALU_SHL, 5'd5, ALU shift-left code
- ALU_AND, 5'd6, ALU and code
- ALU_OR, 5'd7, ALU or code
- ALU_NOR, 5'd8, ALU nor code
- ALU_SLT, 5'd9, ALU set-less-than code

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- INSTRUCTION  in  32  instruction word from the data path
- ZERO  in  1  ALU zero flag
- CTRL  out  32  data-path control word
- READ  out  1  memory read strobe
- WRITE  out  1  memory write strobe
- ILLEGAL  out  1  illegal-instruction flag

Behaviour:
- Reset: RST=0 forces state=FETCH, ir_q=0, zero_q=0, CTRL=0, READ=0, WRITE=0, ILLEGAL=0 immediately (async). First rising CLK with RST=1 begins FETCH.
- State order: FETCH->DECODE->EXE->MEM->WB->FETCH, one cycle each, so every instruction takes exactly 5 cycles. No stalls, no handshake.
- ir_q latches INSTRUCTION on the FETCH->DECODE edge. All decode uses ir_q only.
- zero_q latches ZERO on the EXE->MEM edge.
- CTRL bit map:
  - 0 pc_load; 1 pc_sel_1 (1=pc+1, 0=R[rs]); 2 pc_sel_2 (1=pc+1+simm); 3 pc_sel_3 (0=jump address)
  - 4 mem_r; 5 mem_w
  - 6 r1_sel_1 (1=rs, 0=r0); 7 reg_r; 8 reg_w
  - 9 wa_sel_1 (1=rt, 0=rd); 10 wa_sel_2 (1=r31); 11 wa_sel_3 (1=rt/rd)
  - 12 wd_sel_1 (1=mem); 13 wd_sel_2 (1=lui); 14 wd_sel_3 (1=data, 0=pc+1)
  - 15 sp_load; 16 op1_sel_1 (1=sp)
  - 17 op2_sel_1 (1=shamt, 0=const 1); 18 op2_sel_2 (1=sign-ext); 19 op2_sel_3 (1=shamt/1); 20 op2_sel_4 (1=R[rt])
  - 25:21 alu_oprn; 26 ma_sel_1 (1=sp); 27 dmem_r; 28 dmem_w; 29 md_sel_1 (1=R[rs]); 30 ir_load; 31 ma_sel_2 (1=pc)
- READ = CTRL[4], WRITE = CTRL[5]. The two are never both 1.
- FETCH: CTRL = 0xC0000010.
- DECODE: CTRL = 0x000000C0.
- EXE: reg_r and r1_sel_1 held. ALU operation and operand selects per instruction:
  - R-type: op2_sel_4=1; funct 20/22/2c/24/25/27/2a -> add/sub/mul/and/or/nor/slt.
  - sll (funct 01) -> SHL, srl (funct 02) -> SHR; both op2_sel_4=0, op2_sel_3=1, op2_sel_1=1.
  - addi/muli/slti: sign-ext immediate.
  - andi/ori: zero-ext immediate.
  - beq/bne: SUB with op2_sel_4=1.
  - lw/sw: ADD with sign-ext immediate.
  - push: SUB, op1_sel_1=1, const 1. pop: ADD, op1_sel_1=1, const 1.
- MEM: EXE fields held. CTRL[31]=0.
  - lw: mem_r=1.
  - sw: mem_w=1.
  - push: mem_w=1, ma_sel_1=1, md_sel_1=1, r1_sel_1=0.
  - pop: mem_r=1, ma_sel_1=1.
  - All other instructions: no memory strobe.
- WB: pc_load=1. PC select:
  - Default: pc_sel_1=1, pc_sel_3=1 (PC+1).
  - beq with zero_q=1, or bne with zero_q=0: pc_sel_2=1, pc_sel_3=1.
  - jr: pc_sel_1=0, pc_sel_3=1.
  - jmp/jal: pc_sel_3=0.
- WB register write: reg_w=1, wd_sel_3=1, wa_sel_3=1, with:
  - R-type: wa_sel_1=0.
  - I-type ALU ops: wa_sel_1=1.
  - lw: wa_sel_1=1, wd_sel_1=1.
  - lui: wd_sel_2=1.
  - jal: wa_sel_3=0, wa_sel_2=1, wd_sel_3=0.
  - pop: wa_sel_3=0, wa_sel_2=0, wd_sel_1=1.
- WB stack: push/pop sp_load=1.
- Opcodes: jmp 02, jal 03, beq 04, bne 05, addi 08, slti 0a, andi 0c, ori 0d, lui 0f, push 1b, pop 1c, muli 1d, lw 23, sw 2b. R-type is opcode 00; jr is funct 08.
- RST asserted mid-instruction: the instruction is abandoned, no pc_load or reg_w is issued, and execution restarts at FETCH.

Optional Feature:
- Macro: PROC_ILLEGAL_TRAP_EN.
- Defined: an unrecognised opcode or R-type funct moves DECODE to a sticky HALT state. In HALT, CTRL=0, READ=WRITE=0, ILLEGAL=1 until RST=0.
- Undefined: ILLEGAL is tied 0. An unrecognised instruction executes as a NOP: full 5 cycles, WB issues PC+1 only.

Test Plan:
- Reset: hold RST=0 for 3 cycles -> CTRL=0, READ=0. Release -> first cycle CTRL=0xC0000010, READ=1, WRITE=0.
- add: INSTRUCTION=0x00221820 -> EXE CTRL=0x003000C0; WB CTRL=0x003049CB.
- beq: INSTRUCTION=0x10220003 with ZERO=1 in EXE -> WB CTRL[3:0]=4'b1101. Repeat with ZERO=0 -> WB CTRL[3:0]=4'b1011.
- Memory: lw 0x8C230004 -> READ=1 only in FETCH and MEM; WB has reg_w=1, wd_sel_1=1. sw 0xAC230004 -> WRITE=1 only in MEM, reg_w never asserted.
- Reset mid-operation: RST=0 during EXE of add -> CTRL=0 immediately, no WB. After release, a 5-cycle FETCH sequence restarts.
- Illegal opcode: INSTRUCTION=0xFC000000 with PROC_ILLEGAL_TRAP_EN -> ILLEGAL=1 from EXE cycle onward, CTRL=0 for 20 cycles. Without the macro -> WB CTRL=0x0000000B.
